// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare conditional-branch predictor with a PHT init sweep,
// speculative GHR with mispredict repair, and a saturating mispredict counter.
module gshare_predictor #(
  parameter int IDX_W    = 12,
  parameter int CTR_W    = 2,
  parameter int GHR_W    = 12,
  parameter int CTR_INIT = 2**(CTR_W-1)
)(
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_pc,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [31:0]      mispred_cnt
);
  typedef enum logic {INIT, RUN} state_t;
  state_t           r_state;
  logic [IDX_W-1:0] r_sweep;
  logic [GHR_W-1:0] r_ghr;
  logic             r_ready;
  logic [31:0]      r_cnt;
  logic [CTR_W-1:0] r_pht [2**IDX_W];
  logic [IDX_W-1:0] w_pred_idx, w_upd_idx;
  logic [CTR_W-1:0] w_ctr, w_ctr_nxt;
  logic [GHR_W:0]   w_spec, w_rep;
  logic             w_run, w_misp;
  assign w_run       = r_state == RUN;
  assign w_misp      = upd_valid & upd_mispredict;
  assign w_pred_idx  = pred_pc ^ IDX_W'(r_ghr);
  assign w_upd_idx   = upd_pc ^ IDX_W'(upd_ghr);
  assign w_ctr       = r_pht[w_upd_idx];
  assign pred_taken  = r_ready & r_pht[w_pred_idx][CTR_W-1];
  assign pred_ghr    = r_ghr;
  assign ready       = r_ready;
  assign mispred_cnt = r_cnt;
  // Shift by concatenation then truncation so GHR_W=1 degenerates to ghr <= bit.
  assign w_spec = {r_ghr, pred_taken};
  assign w_rep  = {upd_ghr, upd_taken};
  always_comb
    w_ctr_nxt = upd_taken ? (&w_ctr ? w_ctr : w_ctr + 1'b1)
                          : (|w_ctr ? w_ctr - 1'b1 : w_ctr);
  // PHT carries no reset; the INIT sweep rewrites every entry after each reset.
  always_ff @(posedge clk)
    if (!w_run) r_pht[r_sweep] <= CTR_W'(CTR_INIT);
    else if (upd_valid) r_pht[w_upd_idx] <= w_ctr_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT;
      r_sweep <= '0;
      r_ghr   <= '0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_run) begin
      r_sweep <= r_sweep + 1'b1;
      if (&r_sweep) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end else begin
      if (w_misp) r_ghr <= w_rep[GHR_W-1:0];
      else if (pred_valid) r_ghr <= w_spec[GHR_W-1:0];
      if (w_misp && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised gshare conditional-branch predictor for the RISC-V fetch and execute pipeline. It holds a pattern history table (PHT) of saturating counters, indexed by PC bits XOR a speculative global history register (GHR). Predictions are made at fetch. Resolved branches from execute train the table and repair the GHR on a mispredict. A reset sweep initialises the PHT, and a saturating counter tracks mispredictions.

Parameters:
IDX_W, 12, PHT index width; the PHT has 2**IDX_W entries
CTR_W, 2, saturating counter width; legal range 2..4
GHR_W, 12, global history length; legal range 1..IDX_W; history is zero-extended on the left to IDX_W before the XOR
CTR_INIT, 2**(CTR_W-1), counter value written during the reset sweep (weakly taken)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
ready  output  1  high once the PHT sweep has completed
pred_valid  input  1  a conditional branch is being fetched this cycle
pred_pc  input  IDX_W  PC[IDX_W+1:2] of the fetched branch
pred_taken  output  1  prediction; combinational from the current PHT and GHR
pred_ghr  output  GHR_W  GHR value before this prediction; carried down the pipe as a checkpoint
upd_valid  input  1  a conditional branch resolved in execute this cycle
upd_pc  input  IDX_W  PC[IDX_W+1:2] of the resolved branch
upd_ghr  input  GHR_W  checkpoint pred_ghr captured when the branch was predicted
upd_taken  input  1  actual outcome
upd_mispredict  input  1  actual outcome differs from the prediction; qualified by upd_valid
mispred_cnt  output  32  number of mispredicts since reset; saturates at 0xFFFFFFFF

Behaviour:
- Index rule: pred_idx = pred_pc ^ {0, ghr}; upd_idx = upd_pc ^ {0, upd_ghr}.
- pred_taken = pht[pred_idx][CTR_W-1], the counter MSB. The output is forced to 0 while ready=0.
- pred_ghr = ghr at all times.

Reset and init FSM (states INIT, RUN):
- rst_n low, asynchronously: state=INIT, sweep_ptr=0, ghr=0, ready=0, mispred_cnt=0.
- In INIT: pht[sweep_ptr] <= CTR_INIT each cycle and sweep_ptr increments.
- When sweep_ptr = 2**IDX_W-1 is written, the FSM moves to RUN. ready rises the following cycle, 2**IDX_W cycles after reset deassertion.
- pred_valid and upd_valid are ignored in INIT: no GHR shift, no training.
- Reset asserted mid-sweep or mid-run restarts the sweep from 0.

Training (RUN, upd_valid=1), applied at the next edge:
- upd_taken=1: pht[upd_idx] increments, saturating at 2**CTR_W-1.
- upd_taken=0: pht[upd_idx] decrements, saturating at 0.
- upd_mispredict=1: mispred_cnt increments, saturating.

GHR (RUN):
- Priority 1: upd_valid & upd_mispredict gives ghr <= {upd_ghr[GHR_W-2:0], upd_taken}, the repaired history. A same-cycle pred_valid does not shift the GHR, because fetch is flushed.
- Priority 2: otherwise, pred_valid gives ghr <= {ghr[GHR_W-2:0], pred_taken}, the speculative history.
- For GHR_W=1 the shift reduces to ghr <= bit.

Collision rule:
- When pred_valid and upd_valid target the same index in one cycle, the prediction uses the pre-update counter value (read-before-write).
- The trained value is visible on the next cycle.

Storage:
- The PHT is a single-write-port array with one combinational read port and one read-modify-write port.
- The INIT write and the training write are mutually exclusive by state.

Test Plan:
- Reset, IDX_W=4: release rst_n -> ready=0 for 16 cycles, then 1. All entries read 2'b10, so pred_taken=1 for every pred_pc. mispred_cnt=0 and pred_ghr=0.
- Saturation, ghr=0, pc=5: apply 3 updates with upd_taken=0 -> counter 10,01,00,00, and pred_taken=0 from the first update onward. Then apply 4 updates with taken=1 -> 01,10,11,11.
- Speculative shift, GHR_W=4: 3 predictions with pred_taken=1, 1, then 0 -> pred_ghr goes 0000, 0001, 0011, 0110. The index in use equals pred_pc ^ ghr.
- Repair: GHR=0110 and pred_valid=1 in the same cycle as upd_valid=1, upd_mispredict=1, upd_ghr=0001, upd_taken=0 -> next GHR=0010 with no speculative shift, and mispred_cnt increments by 1.
- Collision: pred_pc and upd_pc hit the same index holding 01 while upd_taken=1 -> pred_taken=0 in that cycle and 1 in the next.
- Async reset mid-sweep: assert rst_n low at cycle 7 without a clock edge -> ready=0 and ghr=0 immediately. After release, the sweep restarts and ready rises after another full 2**IDX_W cycles.
